// File: rtl/regf_bank.sv
// regf_bank
//    Bank of NREG registers, WIDTH bits each, on a single clock. On every clock
//    edge one entry (WSel) may be cleared, loaded from BusOut, incremented or
//    decremented. Any entry (RSel) can be read combinationally. A sticky
//    overflow flag records any applied increment from all-ones or any applied
//    decrement from zero.
//
//    Ports
//       Clk     in   1      clock, every state update happens on its rising edge
//       RST     in   1      synchronous active-high reset
//       Wen     in   1      load BusOut into reg[WSel]
//       INC     in   1      increment reg[WSel]
//       DEC     in   1      decrement reg[WSel]
//       CLR     in   1      reg[WSel] <= SVAL
//       OvfClr  in   1      clear the sticky ovf flag
//       WSel    in   AW     target register for Wen/INC/DEC/CLR
//       RSel    in   AW     read-port select
//       BusOut  in   WIDTH  data bus input
//       dout    out  WIDTH  reg[RSel], or 0 when RSel selects no register
//       z       out  1      dout == 0
//       ovf     out  1      sticky overflow/underflow flag

module regf_bank #(
   parameter int               WIDTH = 8,
   parameter int               NREG  = 4,
   parameter logic [WIDTH-1:0] SVAL  = '0,
   parameter bit               SAT   = 1'b0,
   localparam int              AW    = $clog2(NREG)
) (
   input  logic             Clk,
   input  logic             RST,
   input  logic             Wen,
   input  logic             INC,
   input  logic             DEC,
   input  logic             CLR,
   input  logic             OvfClr,
   input  logic [AW-1:0]    WSel,
   input  logic [AW-1:0]    RSel,
   input  logic [WIDTH-1:0] BusOut,
   output logic [WIDTH-1:0] dout,
   output logic             z,
   output logic             ovf
);

   logic [WIDTH-1:0] regs [NREG];
   logic [WIDTH-1:0] cur_val;
   logic [WIDTH-1:0] next_val;
   logic             wsel_hit;
   logic             do_update;
   logic             ovf_set;

   // Read port: a select that matches no register yields zero, which also
   // covers the unused codes of a non-power-of-two bank.
   always_comb begin
      dout = '0;
      for (int i = 0; i < NREG; i++) begin
         if (RSel == AW'(i)) begin
            dout = regs[i];
         end
      end
   end

   assign z = (dout == '0);

   // Fetch the current value of the write target; wsel_hit stays low when
   // WSel points past the last register so the whole operation is dropped.
   always_comb begin
      cur_val  = '0;
      wsel_hit = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         if (WSel == AW'(i)) begin
            cur_val  = regs[i];
            wsel_hit = 1'b1;
         end
      end
   end

   // Resolve the single operation applied this cycle (CLR > Wen > INC > DEC).
   // Only an operation that actually wins can raise the overflow flag, so a
   // masked INC/DEC below CLR or Wen never sets ovf.
   always_comb begin
      next_val = cur_val;
      ovf_set  = 1'b0;
      if (CLR) begin
         next_val = SVAL;
      end else if (Wen) begin
         next_val = BusOut;
      end else if (INC) begin
         if (cur_val == '1) begin
            next_val = SAT ? cur_val : '0;
            ovf_set  = wsel_hit;
         end else begin
            next_val = cur_val + WIDTH'(1);
         end
      end else if (DEC) begin
         if (cur_val == '0) begin
            next_val = SAT ? cur_val : '1;
            ovf_set  = wsel_hit;
         end else begin
            next_val = cur_val - WIDTH'(1);
         end
      end
   end

   assign do_update = wsel_hit & (CLR | Wen | INC | DEC);

   // Register storage and sticky flag. A new overflow event takes precedence
   // over OvfClr in the same cycle so the event is never lost.
   always_ff @(posedge Clk) begin
      if (RST) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= SVAL;
         end
         ovf <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (do_update && (WSel == AW'(i))) begin
               regs[i] <= next_val;
            end
         end
         ovf <= ovf_set | (ovf & ~OvfClr);
      end
   end

endmodule
